bcd_seq_addsub: RTL and testbench
=================================

# bcd_seq_addsub

Parametrised, digit-serial, multi-digit BCD adder/subtractor with a valid/ready start handshake. It generalises the team's single-digit combinational BCD adder:
- operand width set by `DIGITS` (packed BCD),
- one digit processed per clock, least-significant digit first,
- mode input selecting add or subtract (10's complement),
- sticky invalid-digit detection,
- registered results held until the next operation.

It sits between operand registers and any BCD display or accumulator logic that needs a wide decimal sum without a wide combinational carry chain.

## Interface
Parameters:
- `DIGITS`, default 4: number of BCD digits per operand; legal range ≥1.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_valid`  in  1  request to start an operation.
- `start_ready`  out  1  high only in IDLE; an operation is accepted on an edge where `start_valid & start_ready`.
- `a`  in  4*DIGITS  operand A, packed BCD, digit 0 at [3:0]; sampled at acceptance.
- `b`  in  4*DIGITS  operand B, same format; sampled at acceptance.
- `cin`  in  1  carry-in (add mode) or borrow-in (subtract mode); sampled at acceptance.
- `sub`  in  1  0 = A+B+cin, 1 = A−B−cin; sampled at acceptance.
- `sum`  out  4*DIGITS  result, packed BCD.
- `cout`  out  1  add mode: decimal carry-out; subtract mode: borrow-out (1 when A < B+cin).
- `invalid`  out  1  1 when any digit of the accepted A or B exceeds 9.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  high for exactly one cycle, in DONE.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on acceptance.
  - RUN → DONE after DIGITS digit steps.
  - DONE → IDLE unconditionally after one cycle.
- At acceptance, latch the following, and reset the digit index to 0:
  - A and B;
  - `sub`;
  - initial carry c = `cin` (add) or c = ~`cin` (subtract);
  - `invalid` = OR over all 2*DIGITS digits of (digit > 9), evaluated on the raw B, before complementing.
- At acceptance, clear `sum` and `cout` to 0.
- Each RUN edge processes digit i:
  - b' = b_i (add) or 9 − b_i (subtract).
  - t = a_i + b' + c, 5-bit.
  - If t > 9: sum digit = (t + 6) mod 16, next c = 1.
  - Else: sum digit = t, next c = 0.
  - Write sum digit i, then increment i.
- Last RUN edge (i = DIGITS−1):
  - `cout` = final c (add) or ~final c (subtract).
  - If `invalid`, force `sum` to 0 and `cout` to 0 on this same edge.
- Results wrap modulo 10^DIGITS. Subtract with borrow yields the 10's complement, e.g. 0001−0002 → 9999, `cout`=1.
- `sum`, `cout` and `invalid` hold their values from DONE until the next acceptance.
- `start_valid` during RUN or DONE is ignored; no queuing.
- `a`, `b`, `cin` and `sub` may change freely after acceptance without affecting the operation in flight.

## Timing
- Reset values:
  - state IDLE, `start_ready`=1, `busy`=0, `done`=0;
  - `sum`=0, `cout`=0, `invalid`=0;
  - internal carry and index 0.
- Reset asserted mid-RUN or in DONE aborts immediately. No `done` pulse is produced for the aborted operation.
- Latency: with acceptance on edge E0, digit i is written on edge E(i+1). `done`=1 during the cycle following edge E(DIGITS), and final `sum`/`cout` are valid in that same cycle.
- `start_ready` returns high on the cycle after DONE. Minimum acceptance spacing is DIGITS+2 cycles.
- During RUN, `sum` shows partial results: low digits new, high digits 0. Consumers sample only on `done`.
- `done`, `busy` and `start_ready` are decoded from registered state (glitch-free).
- DIGITS=1: exactly one RUN cycle, then DONE.

## Test plan
All scenarios use DIGITS=4, with values in BCD hex.
- Reset: assert `rst` asynchronously with no clock running → `sum`=0000, `cout`=0, `invalid`=0, `done`=0, `busy`=0, `start_ready`=1.
- Add wrap: A=9999, B=0001, `cin`=0, `sub`=0 → `done` 5 edges after acceptance, `sum`=0000, `cout`=1, `invalid`=0; `start_ready` high again on the next cycle.
- Add with carry-in: A=0456, B=0789, `cin`=1 → `sum`=1246, `cout`=0.
- Subtract: 0100−0001 with `cin`=0 → 0099, `cout`=0. Then 0001−0002 → 9999, `cout`=1. Then 0500−0200 with `cin`=1 → 0299, `cout`=0.
- Invalid digit: A=00A0, B=0001 → `done` at the normal latency, `invalid`=1, `sum`=0000, `cout`=0. The next valid operation clears `invalid`.
- Busy and abort:
  - Pulse `start_valid` with new operands during RUN → ignored; the result matches the first operation.
  - Assert `rst` two edges into RUN → immediate return to reset values with no `done`.
  - After release, 1234+4321 → 5555, `cout`=0.

Source files
------------

// File: rtl/bcd_seq_addsub.sv
// bcd_seq_addsub: digit-serial multi-digit BCD adder/subtractor, one digit per clock, LSD first
module bcd_seq_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    input  logic                  sub,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  invalid,
    output logic                  busy,
    output logic                  done
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    a_r, b_r;
    logic            sub_r, c, accept, last, bad_in, gt;
    logic [IW-1:0]   idx;
    logic [3:0]      b_eff, s_d;
    logic [4:0]      t;

    assign start_ready = state == IDLE;
    assign busy        = state != IDLE;
    assign done        = state == DONE;
    assign accept      = start_valid & start_ready;
    assign last        = idx == IW'(DIGITS - 1);

    always_comb begin
        bad_in = 1'b0;
        for (int k = 0; k < DIGITS; k++)
            bad_in = bad_in | (a[4*k +: 4] > 4'd9) | (b[4*k +: 4] > 4'd9);
    end

    // operands shift right each step, so the active digit is always at [3:0]
    always_comb begin
        b_eff = sub_r ? 4'd9 - b_r[3:0] : b_r[3:0];
        t     = {1'b0, a_r[3:0]} + {1'b0, b_eff} + {4'b0, c};
        gt    = t > 5'd9;
        s_d   = gt ? t[3:0] + 4'd6 : t[3:0];
    end

    always_comb begin
        state_nx = state == IDLE ? (accept ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            sub_r   <= 1'b0;
            c       <= 1'b0;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            invalid <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_r     <= a;
                b_r     <= b;
                sub_r   <= sub;
                c       <= sub ? ~cin : cin;
                idx     <= '0;
                invalid <= bad_in;
                sum     <= '0;
                cout    <= 1'b0;
            end else if (state == RUN) begin
                a_r              <= a_r >> 4;
                b_r              <= b_r >> 4;
                c                <= gt;
                idx              <= idx + 1'b1;
                sum[4*idx +: 4]  <= s_d;
                if (last) begin
                    cout <= ~invalid & (gt ^ sub_r);
                    if (invalid)
                        sum <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_seq_addsub.sv
// tb_bcd_seq_addsub: randomized and directed checks of bcd_seq_addsub against a decimal-arithmetic model
module tb_bcd_seq_addsub;
    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk = 1'b0, clk_en = 1'b0, rst = 1'b0;
    logic         start_valid = 1'b0, cin = 1'b0, sub = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         start_ready, cout, invalid, busy, done;
    logic [W-1:0] sum;

    int           tests = 0, fails = 0, lat = 0;
    bit           pend = 0, held = 0, chk_rdy = 0;
    logic [W-1:0] e_sum = '0;
    bit           e_cout = 0, e_inv = 0;

    bcd_seq_addsub #(.DIGITS(D)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .sum(sum), .cout(cout),
        .invalid(invalid), .busy(busy), .done(done)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // plain decimal arithmetic on the integer values of the BCD operands
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input bit ci,
                                  input bit sb, output logic [W-1:0] s, output bit co, output bit inv);
        int xv, yv, r, m;
        xv = 0; yv = 0; m = 1; inv = 0;
        for (int k = D - 1; k >= 0; k--) begin
            xv  = xv * 10 + int'(x[4*k +: 4]);
            yv  = yv * 10 + int'(y[4*k +: 4]);
            inv = inv | (x[4*k +: 4] > 4'd9) | (y[4*k +: 4] > 4'd9);
            m   = m * 10;
        end
        r  = sb ? xv - yv - int'(ci) : xv + yv + int'(ci);
        co = sb ? (r < 0) : (r >= m);
        r  = (r + m) % m;
        s  = '0;
        for (int k = 0; k < D; k++) begin
            s[4*k +: 4] = 4'(r % 10);
            r = r / 10;
        end
        if (inv) begin
            s  = '0;
            co = 0;
        end
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!start_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input bit ci, input bit sb,
                      input logic [W-1:0] es, input bit ec, input bit ei, input bit poke);
        int n = 0;
        wait_ready();
        a = x; b = y; cin = ci; sub = sb; start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        e_sum = es; e_cout = ec; e_inv = ei; lat = 0; held = 0; pend = 1;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        if (poke) begin
            @(negedge clk);
            @(negedge clk);
            a = 16'h8888; b = 16'h1111; cin = 1'b1; sub = 1'b0; start_valid = 1'b1;
            @(negedge clk);
            start_valid = 1'b0;
        end
        while (pend && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic rand_op();
        logic [W-1:0] x, y, s;
        bit ci, sb, co, inv;
        for (int k = 0; k < D; k++) begin
            x[4*k +: 4] = 4'($urandom_range(0, 9));
            y[4*k +: 4] = 4'($urandom_range(0, 9));
        end
        if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 1) x[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
            else                           y[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
        end
        ci = 1'($urandom);
        sb = 1'($urandom);
        model(x, y, ci, sb, s, co, inv);
        op(x, y, ci, sb, s, co, inv, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (chk_rdy) begin
                        check("ready_after_done", {start_ready, busy, done}, 3'b100);
                        chk_rdy = 0;
                    end
                    if (pend) begin
                        lat++;
                        if (done) begin
                            check("latency", lat, D + 1);
                            check("sum", sum, e_sum);
                            check("cout", cout, e_cout);
                            check("invalid", invalid, e_inv);
                            pend = 0; held = 1; chk_rdy = 1;
                        end else if (lat > D + 1) begin
                            check("done_timeout", done, 1);
                            pend = 0;
                        end else
                            check("busy_run", {start_ready, busy, done}, 3'b010);
                    end else if (held && start_ready) begin
                        check("hold_sum", sum, e_sum);
                        check("hold_flags", {cout, invalid}, {e_cout, e_inv});
                    end
                end
            end
        join_none

        #3 rst = 1'b1;
        #2 check("reset_no_clk", {sum, cout, invalid, done, busy, start_ready}, {16'h0, 5'b00001});
        #5 rst = 1'b0;
        clk_en = 1'b1;

        op(16'h9999, 16'h0001, 0, 0, 16'h0000, 1, 0, 0);
        op(16'h0456, 16'h0789, 1, 0, 16'h1246, 0, 0, 0);
        op(16'h0100, 16'h0001, 0, 1, 16'h0099, 0, 0, 0);
        op(16'h0001, 16'h0002, 0, 1, 16'h9999, 1, 0, 0);
        op(16'h0500, 16'h0200, 1, 1, 16'h0299, 0, 0, 0);
        op(16'h00A0, 16'h0001, 0, 0, 16'h0000, 0, 1, 0);
        op(16'h0003, 16'h0004, 0, 0, 16'h0007, 0, 0, 0);
        op(16'h0012, 16'h0034, 0, 0, 16'h0046, 0, 0, 1);

        wait_ready();
        held = 0;
        a = 16'h5678; b = 16'h1111; cin = 1'b0; sub = 1'b0; start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check("abort_reset", {sum, cout, invalid, done, busy, start_ready}, {16'h0, 5'b00001});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (D + 3) begin
            @(negedge clk);
            check("no_done_after_abort", {done, start_ready}, 2'b01);
        end
        op(16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0, 0);

        repeat (40) rand_op();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
